sec32_encoder: RTL and testbench

- Streaming single-error-correcting check-bit generator for 32-bit data words.
- Transmit end of the 32-data/8-check SEC protocol. Its output codeword goes unchanged to the 32-bit SEC corrector, which must pass the data bits through with no correction applied.
- Has a valid/ready input handshake and a 2-entry registered output buffer.
- Has a one-shot single-bit error-injection facility for verifying the corrector.

---
 rtl/sec32_encoder.sv | 142 ++++++++++++++
 tb/tb_sec32_encoder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sec32_encoder.sv
// Streaming SEC check-bit generator: 32 data + 8 check bits, valid/ready input,
// 2-entry registered output buffer, one-shot single-bit error injection.
module sec32_encoder #(
  parameter int CNT_W  = 16,
  parameter bit INJ_EN = 1'b1
) (
  input  logic             Gclk,
  input  logic             Grst_n,
  input  logic             Gin_valid,
  output logic             Gin_ready,
  input  logic [31:0]      Gid,
  output logic             Gout_valid,
  input  logic             Gout_ready,
  output logic [31:0]      God,
  output logic [7:0]       Goc,
  input  logic             Ginj_req,
  input  logic [5:0]       Ginj_pos,
  output logic             Ginj_busy,
  output logic [CNT_W-1:0] Gcnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  // Data-bit membership of each check bit (bit k of the mask selects dk).
  function automatic logic [31:0] check_mask(input int idx);
    case (idx)
      0:       check_mask = 32'h00FF_1111;
      1:       check_mask = 32'hFF00_2222;
      2:       check_mask = 32'h0F0F_4444;
      3:       check_mask = 32'hF0F0_8888;
      4:       check_mask = 32'h1111_00FF;
      5:       check_mask = 32'h2222_FF00;
      6:       check_mask = 32'h4444_0F0F;
      default: check_mask = 32'h8888_F0F0;
    endcase
  endfunction

  state_t        state_reg, state_next;
  logic [39:0]   head_reg, tail_reg;
  logic [39:0]   cw_next, flip_mask;
  logic [7:0]    chk;
  logic [CNT_W-1:0] cnt_reg;
  logic          inj_busy_reg;
  logic [5:0]    inj_pos_reg;
  logic          push, pop;
  logic          head_we, head_from_tail, tail_we;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_chk
      assign chk[gi] = ^(Gid & check_mask(gi));
    end
  endgenerate

  assign Gin_ready  = (state_reg != TWO);
  assign Gout_valid = (state_reg != EMPTY);
  assign push       = Gin_valid && Gin_ready;
  assign pop        = Gout_valid && Gout_ready;
  assign God        = head_reg[31:0];
  assign Goc        = head_reg[39:32];
  assign Gcnt       = cnt_reg;
  assign Ginj_busy  = inj_busy_reg;

  // Positions 40..63 consume an armed injection without flipping anything.
  assign flip_mask = (inj_busy_reg && (inj_pos_reg < 6'd40)) ? (40'd1 << inj_pos_reg) : 40'd0;
  assign cw_next   = {chk, Gid} ^ flip_mask;

  always_comb begin
    state_next     = state_reg;
    head_we        = 1'b0;
    head_from_tail = 1'b0;
    tail_we        = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (push) begin
          state_next = ONE;
          head_we    = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_we = 1'b1;
        end else if (push) begin
          state_next = TWO;
          tail_we    = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_next     = ONE;
          head_from_tail = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge Gclk or negedge Grst_n) begin
    if (!Grst_n) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
      tail_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (head_we)
        head_reg <= cw_next;
      else if (head_from_tail)
        head_reg <= tail_reg;
      if (tail_we)
        tail_reg <= cw_next;
      if (push)
        cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  generate
    if (INJ_EN) begin : g_inj
      // Consumption uses the pre-edge busy, so a request in the same cycle as
      // an acceptance arms for the following word.
      always_ff @(posedge Gclk or negedge Grst_n) begin
        if (!Grst_n) begin
          inj_busy_reg <= 1'b0;
          inj_pos_reg  <= '0;
        end else if (!inj_busy_reg) begin
          if (Ginj_req) begin
            inj_busy_reg <= 1'b1;
            inj_pos_reg  <= Ginj_pos;
          end
        end else if (push) begin
          inj_busy_reg <= 1'b0;
        end
      end
    end else begin : g_no_inj
      assign inj_busy_reg = 1'b0;
      assign inj_pos_reg  = 6'd0;
    end
  endgenerate

endmodule

// File: tb/tb_sec32_encoder.sv
// Randomised and directed self-checking bench for sec32_encoder against a
// queue-based behavioural model of the codec and buffer.
module tb_sec32_encoder;

  logic        Gclk = 1'b0;
  logic        Grst_n = 1'b0;
  logic        Gin_valid = 1'b0;
  logic [31:0] Gid = '0;
  logic        Gout_ready = 1'b0;
  logic        Ginj_req = 1'b0;
  logic [5:0]  Ginj_pos = '0;
  logic        Gin_ready, Gout_valid, Ginj_busy;
  logic [31:0] God;
  logic [7:0]  Goc;
  logic [15:0] Gcnt;
  logic        r4_in_ready, r4_out_valid, r4_busy;
  logic [31:0] r4_od;
  logic [7:0]  r4_oc;
  logic [3:0]  r4_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model state
  logic [39:0] mq[$];
  logic [15:0] mcnt;
  logic [3:0]  mcnt4;
  bit          mbusy;
  int          mpos;

  always #5 Gclk = ~Gclk;

  sec32_encoder dut (
    .Gclk(Gclk), .Grst_n(Grst_n), .Gin_valid(Gin_valid), .Gin_ready(Gin_ready),
    .Gid(Gid), .Gout_valid(Gout_valid), .Gout_ready(Gout_ready), .God(God), .Goc(Goc),
    .Ginj_req(Ginj_req), .Ginj_pos(Ginj_pos), .Ginj_busy(Ginj_busy), .Gcnt(Gcnt)
  );

  sec32_encoder #(.CNT_W(4), .INJ_EN(1'b0)) dut4 (
    .Gclk(Gclk), .Grst_n(Grst_n), .Gin_valid(Gin_valid), .Gin_ready(r4_in_ready),
    .Gid(Gid), .Gout_valid(r4_out_valid), .Gout_ready(Gout_ready), .God(r4_od), .Goc(r4_oc),
    .Ginj_req(Ginj_req), .Ginj_pos(Ginj_pos), .Ginj_busy(r4_busy), .Gcnt(r4_cnt)
  );

  // Check bits from the membership rules: low half groups by bit-in-nibble and
  // nibble/byte index, high half groups by nibble pair and bit-in-nibble.
  function automatic logic [7:0] ref_chk(input logic [31:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) begin
        if (i < 16) begin
          c[i % 4] ^= 1'b1;
          c[4 + (i / 8)] ^= 1'b1;
          c[6 + ((i / 4) % 2)] ^= 1'b1;
        end else begin
          int j;
          j = i - 16;
          c[(j / 8)] ^= 1'b1;
          c[2 + ((j / 4) % 2)] ^= 1'b1;
          c[4 + (j % 4)] ^= 1'b1;
        end
      end
    end
    return c;
  endfunction

  task automatic model_clear();
    mq.delete();
    mcnt = '0;
    mcnt4 = '0;
    mbusy = 1'b0;
    mpos = 0;
  endtask

  // Drive one cycle of stimulus, advance the model across the edge, return at negedge.
  task automatic drive_edge(input bit v, input logic [31:0] d, input bit ordy,
                            input bit req, input logic [5:0] pos);
    bit acc, pop, old_busy;
    logic [39:0] cw;
    Gin_valid = v; Gid = d; Gout_ready = ordy; Ginj_req = req; Ginj_pos = pos;
    @(posedge Gclk);
    acc = v && (mq.size() < 2);
    pop = (mq.size() > 0) && ordy;
    old_busy = mbusy;
    cw = {ref_chk(d), d};
    if (acc && old_busy) begin
      if (mpos < 40) cw[mpos] = ~cw[mpos];
      mbusy = 1'b0;
    end
    if (req && !old_busy) begin
      mbusy = 1'b1;
      mpos = int'(pos);
    end
    if (pop) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(cw);
      mcnt++;
      mcnt4++;
    end
    @(negedge Gclk);
  endtask

  task automatic do_reset();
    Gin_valid = 0; Gout_ready = 0; Ginj_req = 0; Gid = '0; Ginj_pos = '0;
    @(negedge Gclk);
    Grst_n = 1'b0;
    repeat (2) @(negedge Gclk);
    Grst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (Gout_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", Gout_valid); else pass_cnt++;
    total_cnt++; if (Gin_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", Gin_ready); else pass_cnt++;
    total_cnt++; if ({God, Goc} !== 40'd0) $display("FAIL reset_data: got %h/%h want 0/0", God, Goc); else pass_cnt++;
    total_cnt++; if (Gcnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", Gcnt); else pass_cnt++;
    total_cnt++; if (Ginj_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Ginj_busy); else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [31:0] words[4];
    logic [7:0]  want_c[4];
    words  = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    want_c = '{8'h00, 8'h00, 8'h51, 8'h8A};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_edge(1, words[i], 1, 0, 0);
      $display("basic: Gid=%h God=%h Goc=%h", words[i], God, Goc);
      total_cnt++; if (Gout_valid !== 1'b1) $display("FAIL basic_valid[%0d]: got %b want 1", i, Gout_valid); else pass_cnt++;
      total_cnt++; if (God !== words[i]) $display("FAIL basic_od[%0d]: got %h want %h", i, God, words[i]); else pass_cnt++;
      total_cnt++; if (Goc !== want_c[i]) $display("FAIL basic_oc[%0d]: got %h want %h", i, Goc, want_c[i]); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w[3];
    w = '{32'hDEAD_BEEF, 32'h0123_4567, 32'hCAFE_F00D};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_edge(1, w[i], 0, 0, 0);
      total_cnt++; if (Gin_ready !== (i == 0)) $display("FAIL bp_ready[%0d]: got %b want %b", i, Gin_ready, (i == 0)); else pass_cnt++;
      total_cnt++; if ({Goc, God} !== {ref_chk(w[0]), w[0]}) $display("FAIL bp_hold[%0d]: got %h want %h", i, God, w[0]); else pass_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      drive_edge(0, 0, 1, 0, 0);
      $display("drain: God=%h valid=%b ready=%b", God, Gout_valid, Gin_ready);
      total_cnt++; if (Gin_ready !== 1'b1) $display("FAIL bp_ready_after_pop[%0d]: got %b want 1", i, Gin_ready); else pass_cnt++;
      total_cnt++; if (Gout_valid !== (i == 0)) $display("FAIL bp_drain_valid[%0d]: got %b want %b", i, Gout_valid, (i == 0)); else pass_cnt++;
      if (i == 0) begin
        total_cnt++; if (God !== w[1]) $display("FAIL bp_order: got %h want %h", God, w[1]); else pass_cnt++;
      end
    end
    total_cnt++; if (Gcnt !== 16'd2) $display("FAIL bp_cnt: got %0d want 2", Gcnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      drive_edge(1, d, 1, 0, 0);
      total_cnt++; if (Gout_valid !== 1'b1 || God !== d) $display("FAIL b2b[%0d]: got v=%b %h want v=1 %h", i, Gout_valid, God, d); else pass_cnt++;
    end
    total_cnt++; if (Gcnt !== 16'd8) $display("FAIL b2b_cnt: got %0d want 8", Gcnt); else pass_cnt++;
  endtask

  task automatic test_inject();
    do_reset();
    drive_edge(0, 0, 1, 1, 6'd5);
    total_cnt++; if (Ginj_busy !== 1'b1) $display("FAIL inj_arm: got %b want 1", Ginj_busy); else pass_cnt++;
    drive_edge(1, 32'h0, 1, 0, 0);
    $display("inj pos5: God=%h Goc=%h busy=%b", God, Goc, Ginj_busy);
    total_cnt++; if ({God, Goc} !== {32'h20, 8'h00}) $display("FAIL inj_pos5: got %h/%h want 00000020/00", God, Goc); else pass_cnt++;
    total_cnt++; if (Ginj_busy !== 1'b0) $display("FAIL inj_clear: got %b want 0", Ginj_busy); else pass_cnt++;
    drive_edge(1, 32'h1234_5678, 1, 0, 0);
    total_cnt++; if ({God, Goc} !== {32'h1234_5678, ref_chk(32'h1234_5678)}) $display("FAIL inj_clean_next: got %h/%h", God, Goc); else pass_cnt++;
    drive_edge(0, 0, 1, 1, 6'd33);
    drive_edge(1, 32'h1, 1, 0, 0);
    total_cnt++; if ({God, Goc} !== {32'h1, 8'h53}) $display("FAIL inj_pos33: got %h/%h want 00000001/53", God, Goc); else pass_cnt++;
    drive_edge(0, 0, 1, 1, 6'd45);
    drive_edge(1, 32'hA5A5_5A5A, 1, 0, 0);
    total_cnt++; if ({God, Goc} !== {32'hA5A5_5A5A, ref_chk(32'hA5A5_5A5A)}) $display("FAIL inj_pos45: got %h/%h", God, Goc); else pass_cnt++;
    total_cnt++; if (Ginj_busy !== 1'b0) $display("FAIL inj_pos45_clear: got %b want 0", Ginj_busy); else pass_cnt++;
    // Same-cycle request and acceptance flips the following word only.
    drive_edge(1, 32'h0F0F_0000, 1, 1, 6'd0);
    total_cnt++; if (God !== 32'h0F0F_0000) $display("FAIL inj_same_cycle: got %h want 0f0f0000", God); else pass_cnt++;
    drive_edge(1, 32'h0F0F_0000, 1, 0, 0);
    total_cnt++; if (God !== 32'h0F0F_0001) $display("FAIL inj_following: got %h want 0f0f0001", God); else pass_cnt++;
    // A second request while armed must not replace the latched position.
    drive_edge(0, 0, 1, 1, 6'd3);
    drive_edge(0, 0, 1, 1, 6'd7);
    drive_edge(1, 32'h0, 1, 0, 0);
    total_cnt++; if (God !== 32'h8) $display("FAIL inj_ignore_rearm: got %h want 00000008", God); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_edge(1, 32'h1111_1111, 0, 0, 0);
    drive_edge(1, 32'h2222_2222, 0, 1, 6'd9);
    total_cnt++; if (Gin_ready !== 1'b0 || Ginj_busy !== 1'b1) $display("FAIL ar_setup: got ready=%b busy=%b want 0/1", Gin_ready, Ginj_busy); else pass_cnt++;
    #2 Grst_n = 1'b0;
    #1;
    $display("async reset: valid=%b ready=%b cnt=%0d busy=%b", Gout_valid, Gin_ready, Gcnt, Ginj_busy);
    total_cnt++; if ({Gout_valid, Gin_ready, Ginj_busy} !== 3'b010) $display("FAIL ar_flags: got %b want 010", {Gout_valid, Gin_ready, Ginj_busy}); else pass_cnt++;
    total_cnt++; if (Gcnt !== 16'd0 || {God, Goc} !== 40'd0) $display("FAIL ar_regs: got cnt=%0d data=%h want 0/0", Gcnt, God); else pass_cnt++;
    @(negedge Gclk);
    Grst_n = 1'b1;
    model_clear();
    drive_edge(1, 32'h3333_3333, 1, 0, 0);
    total_cnt++; if (God !== 32'h3333_3333 || Gcnt !== 16'd1) $display("FAIL ar_first_accept: got %h cnt=%0d", God, Gcnt); else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) drive_edge(1, $urandom, 1, 1, 6'($urandom_range(0, 63)));
    $display("wrap: cnt4=%0d cnt16=%0d", r4_cnt, Gcnt);
    total_cnt++; if (r4_cnt !== 4'd1) $display("FAIL wrap_cnt4: got %0d want 1", r4_cnt); else pass_cnt++;
    total_cnt++; if (Gcnt !== 16'd17) $display("FAIL wrap_cnt16: got %0d want 17", Gcnt); else pass_cnt++;
    total_cnt++; if (r4_busy !== 1'b0) $display("FAIL noinj_busy: got %b want 0", r4_busy); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [39:0] head;
    int errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      drive_edge($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 9) == 0, 6'($urandom_range(0, 47)));
      head = (mq.size() > 0) ? mq[0] : 40'd0;
      total_cnt++;
      if (Gout_valid !== (mq.size() > 0) || Gin_ready !== (mq.size() < 2) ||
          Ginj_busy !== mbusy || Gcnt !== mcnt || r4_cnt !== mcnt4 ||
          (mq.size() > 0 && {Goc, God} !== head)) begin
        $display("FAIL rand[%0d]: got v=%b r=%b b=%b cnt=%0d cw=%h want v=%b r=%b b=%b cnt=%0d cw=%h",
                 i, Gout_valid, Gin_ready, Ginj_busy, Gcnt, {Goc, God},
                 (mq.size() > 0), (mq.size() < 2), mbusy, mcnt, head);
        errs++;
      end else pass_cnt++;
    end
    $display("random: 400 cycles, %0d mismatching cycles, %0d words", errs, mcnt);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_inject();
    test_async_reset();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
